ifetch_queue: RTL and testbench

//  Fetch stage feeding the 64-word instruction memory. Owns the fetch PC and drives
//  the word address to imem, whose read data is combinational. Buffers fetched
//  {pc, instr} pairs in a small FIFO and hands them to decode over a valid/ready

---
 rtl/ifetch_queue.sv | 118 +++++++++++
 tb/tb_ifetch_queue.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_queue.sv
// Fetch stage: owns the fetch PC, reads imem and queues {pc, instr} pairs for decode.
// Optional IFQ_PERF_EN adds fetch_cnt / flush_cnt performance counters.
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter int          AW       = 6,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [AW-1:0] imem_a,
  input  logic [31:0]   imem_rd,
  input  logic          redirect,
  input  logic [31:0]   redirect_pc,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [31:0]   instr,
  output logic [31:0]   instr_pc
`ifdef IFQ_PERF_EN
  ,
  output logic [15:0]   fetch_cnt,
  output logic [15:0]   flush_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {FETCH, FULL, BUBBLE} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  state_t          state, state_d;
  entry_t          mem [DEPTH];
  entry_t          head;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [PW:0]     count, count_d;
  logic [31:0]     fetch_pc;
  logic            push, pop;
  logic            unused_bits;

  assign unused_bits = ^redirect_pc[1:0];

  assign imem_a      = fetch_pc[AW+1:2];
  assign instr_valid = (count != '0);
  assign head        = mem[rd_ptr];
  assign instr       = instr_valid ? head.instr : 32'h0;
  assign instr_pc    = instr_valid ? head.pc    : 32'h0;

  // Room is judged on the pre-pop count, so a pop never enables a same-cycle push.
  assign pop  = instr_valid && instr_ready;
  assign push = (state == FETCH) && (count < DEPTH_C) && !redirect;

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    count_d = count;
    if (redirect)          count_d = '0;
    else if (push && !pop) count_d = count + 1'b1;
    else if (pop && !push) count_d = count - 1'b1;

    state_d = state;
    case (state)
      FETCH:   if (count_d == DEPTH_C) state_d = FULL;
      FULL:    if (pop) state_d = FETCH;
      BUBBLE:  state_d = FETCH;
      default: state_d = FETCH;
    endcase
    if (redirect) state_d = BUBBLE;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FETCH;
      fetch_pc <= RESET_PC;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      // NOTE: the queue storage is reset too, so entries read back as 0 after reset.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      state <= state_d;
      count <= count_d;
      if (redirect) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        fetch_pc <= {redirect_pc[31:2], 2'b00};
      end else begin
        if (push) begin
          mem[wr_ptr] <= '{pc: fetch_pc, instr: imem_rd};
          wr_ptr      <= wr_ptr + 1'b1;
          fetch_pc    <= fetch_pc + 32'd4;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

`ifdef IFQ_PERF_EN
  // A flush counts only when something besides a consumed head is thrown away.
  logic discard;
  assign discard = redirect && (count != '0) && !((count == (PW+1)'(1)) && pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (push)    fetch_cnt <= fetch_cnt + 16'd1;
      if (discard) flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_ifetch_queue;

  localparam int          DEPTH    = 4;
  localparam int          AW       = 6;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] imem_a;
  logic [31:0]   imem_rd;
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic          instr_valid;
  logic          instr_ready;
  logic [31:0]   instr;
  logic [31:0]   instr_pc;
`ifdef IFQ_PERF_EN
  logic [15:0]   fetch_cnt, flush_cnt;
`endif

  logic [31:0] imem_mem [1 << AW];
  assign imem_rd = imem_mem[imem_a];

  ifetch_queue #(.DEPTH(DEPTH), .AW(AW), .RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_a      (imem_a),
    .imem_rd     (imem_rd),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc)
`ifdef IFQ_PERF_EN
    ,
    .fetch_cnt   (fetch_cnt),
    .flush_cnt   (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: a plain queue of fetched pairs plus the next fetch address.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        m_q [$];
  logic [31:0] m_pc;
  bit          m_bubble;
  logic [15:0] m_fetch, m_flush;
  int          n_pass, n_total;

  function automatic logic e_valid();
    return m_q.size() != 0;
  endfunction
  function automatic logic [31:0] e_instr();
    return (m_q.size() != 0) ? m_q[0].ins : 32'h0;
  endfunction
  function automatic logic [31:0] e_pc();
    return (m_q.size() != 0) ? m_q[0].pc : 32'h0;
  endfunction
  function automatic logic [AW-1:0] e_a();
    return m_pc[AW+1:2];
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_pc     = RESET_PC;
    m_bubble = 1'b0;
    m_fetch  = '0;
    m_flush  = '0;
  endtask

  // Drive one cycle of inputs, advance the model, and land on the next falling edge.
  task automatic tick(input logic rdy, input logic rd, input logic [31:0] rpc);
    bit   pop, push;
    ent_t e;
    instr_ready = rdy;
    redirect    = rd;
    redirect_pc = rpc;
    pop  = (m_q.size() != 0) && rdy;
    push = !m_bubble && (m_q.size() < DEPTH) && !rd;
    if (rd) begin
      if (m_q.size() > (pop ? 1 : 0)) m_flush = m_flush + 16'd1;
      m_q.delete();
      m_pc     = {rpc[31:2], 2'b00};
      m_bubble = 1'b1;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (push) begin
        e.pc  = m_pc;
        e.ins = imem_mem[m_pc[AW+1:2]];
        m_q.push_back(e);
        m_pc    = m_pc + 32'd4;
        m_fetch = m_fetch + 16'd1;
      end
      m_bubble = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    rst_n       = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    rst_n       = 1'b0;
    model_reset();
    #1;
    n_total++; if (instr_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", instr_valid); else n_pass++;
    n_total++; if (instr !== 32'h0) $display("FAIL reset_instr: got %h want 0", instr); else n_pass++;
    n_total++; if (instr_pc !== 32'h0) $display("FAIL reset_pc: got %h want 0", instr_pc); else n_pass++;
`ifdef IFQ_PERF_EN
    n_total++; if (fetch_cnt !== 16'h0 || flush_cnt !== 16'h0) $display("FAIL reset_perf: got %h/%h want 0/0", fetch_cnt, flush_cnt); else n_pass++;
`endif
    @(negedge clk);
    rst_n = 1'b1;
    n_total++; if (imem_a !== 6'd0) $display("FAIL cycle0_addr: got %0d want 0", imem_a); else n_pass++;
    tick(1'b1, 1'b0, 32'h0);
    n_total++; if (instr_valid !== 1'b1) $display("FAIL cycle1_valid: got %b want 1", instr_valid); else n_pass++;
    n_total++; if (instr !== 32'h20020005) $display("FAIL cycle1_instr: got %h want 20020005", instr); else n_pass++;
    n_total++; if (instr_pc !== 32'h0) $display("FAIL cycle1_pc: got %h want 0", instr_pc); else n_pass++;
    for (int i = 1; i <= 3; i++) begin
      tick(1'b1, 1'b0, 32'h0);
      n_total++; if (instr_pc !== 32'(4 * i)) $display("FAIL step_pc: got %h want %h", instr_pc, 32'(4 * i)); else n_pass++;
    end
  endtask

  task automatic test_stall_fill();
    apply_reset();
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 32'h0);
    n_total++; if (imem_a !== 6'd4) $display("FAIL full_addr: got %0d want 4", imem_a); else n_pass++;
    n_total++; if (instr_pc !== 32'h0 || instr_valid !== 1'b1) $display("FAIL full_head: got %b/%h want 1/0", instr_valid, instr_pc); else n_pass++;
`ifdef IFQ_PERF_EN
    n_total++; if (fetch_cnt !== 16'd4) $display("FAIL full_fetch_cnt: got %0d want 4", fetch_cnt); else n_pass++;
`endif
    instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_total++; if (instr_valid !== 1'b1 || instr_pc !== 32'(4 * i))
        $display("FAIL drain_order: got %b/%h want 1/%h", instr_valid, instr_pc, 32'(4 * i)); else n_pass++;
      tick(1'b1, 1'b0, 32'h0);
    end
  endtask

  task automatic test_redirect_full();
    apply_reset();
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b1, 32'h3D);
    n_total++; if (instr_valid !== 1'b0) $display("FAIL flush_valid: got %b want 0", instr_valid); else n_pass++;
    n_total++; if (imem_a !== 6'd15) $display("FAIL flush_addr: got %0d want 15", imem_a); else n_pass++;
    tick(1'b0, 1'b0, 32'h0);
    n_total++; if (instr_valid !== 1'b0) $display("FAIL bubble_valid: got %b want 0", instr_valid); else n_pass++;
    tick(1'b0, 1'b0, 32'h0);
    n_total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h3C) $display("FAIL target_head: got %b/%h want 1/3c", instr_valid, instr_pc); else n_pass++;
    n_total++; if (instr !== imem_mem[15]) $display("FAIL target_instr: got %h want %h", instr, imem_mem[15]); else n_pass++;
`ifdef IFQ_PERF_EN
    n_total++; if (flush_cnt !== 16'd1) $display("FAIL flush_cnt: got %0d want 1", flush_cnt); else n_pass++;
`endif
  endtask

  task automatic test_wrap();
    bit seen;
    seen = 1'b0;
    tick(1'b1, 1'b1, 32'hF0);
    for (int i = 0; i < 12 && !seen; i++) begin
      tick(1'b1, 1'b0, 32'h0);
      n_total++; if (imem_a !== e_a() || instr_pc !== e_pc()) $display("FAIL wrap_track: got %0d/%h want %0d/%h", imem_a, instr_pc, e_a(), e_pc()); else n_pass++;
      if (instr_valid && instr_pc == 32'h100) begin
        seen = 1'b1;
        n_total++; if (instr !== imem_mem[0]) $display("FAIL wrap_instr: got %h want %h", instr, imem_mem[0]); else n_pass++;
        n_total++; if (imem_a !== 6'd1) $display("FAIL wrap_addr: got %0d want 1", imem_a); else n_pass++;
      end
    end
    n_total++; if (!seen) $display("FAIL wrap_timeout: got no pc 100 want pc 100 within 12 cycles"); else n_pass++;
  endtask

  task automatic test_back_to_back_redirect();
    tick(1'b1, 1'b1, 32'h40);
    tick(1'b1, 1'b1, 32'h80);
    n_total++; if (instr_valid !== 1'b0 || imem_a !== 6'h20) $display("FAIL b2b_bubble: got %b/%0d want 0/32", instr_valid, imem_a); else n_pass++;
    tick(1'b1, 1'b0, 32'h0);
    n_total++; if (instr_valid !== 1'b0) $display("FAIL b2b_early: got %b want 0", instr_valid); else n_pass++;
    tick(1'b1, 1'b0, 32'h0);
    n_total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h80) $display("FAIL b2b_first: got %b/%h want 1/80", instr_valid, instr_pc); else n_pass++;
  endtask

  task automatic test_random();
    logic        rdy, rd;
    logic [31:0] tgt;
    for (int i = 0; i < 400; i++) begin
      rdy = ($urandom_range(0, 3) != 0);
      rd  = ($urandom_range(0, 15) == 0);
      tgt = $urandom;
      tick(rdy, rd, tgt);
      n_total++; if (instr_valid !== e_valid()) $display("FAIL rnd_valid: got %b want %b", instr_valid, e_valid()); else n_pass++;
      n_total++; if (instr !== e_instr()) $display("FAIL rnd_instr: got %h want %h", instr, e_instr()); else n_pass++;
      n_total++; if (instr_pc !== e_pc()) $display("FAIL rnd_pc: got %h want %h", instr_pc, e_pc()); else n_pass++;
      n_total++; if (imem_a !== e_a()) $display("FAIL rnd_addr: got %0d want %0d", imem_a, e_a()); else n_pass++;
`ifdef IFQ_PERF_EN
      n_total++; if (fetch_cnt !== m_fetch || flush_cnt !== m_flush)
        $display("FAIL rnd_perf: got %0d/%0d want %0d/%0d", fetch_cnt, flush_cnt, m_fetch, m_flush); else n_pass++;
`endif
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 32'h0);
    n_total++; if (instr_valid !== 1'b1 || imem_a !== 6'd3) $display("FAIL pre_reset: got %b/%0d want 1/3", instr_valid, imem_a); else n_pass++;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_total++; if (instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0)
      $display("FAIL async_clear: got %b/%h/%h want 0/0/0", instr_valid, instr, instr_pc); else n_pass++;
    n_total++; if (imem_a !== RESET_PC[AW+1:2]) $display("FAIL async_addr: got %0d want %0d", imem_a, RESET_PC[AW+1:2]); else n_pass++;
`ifdef IFQ_PERF_EN
    n_total++; if (fetch_cnt !== 16'h0 || flush_cnt !== 16'h0) $display("FAIL async_perf: got %h/%h want 0/0", fetch_cnt, flush_cnt); else n_pass++;
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick(1'b1, 1'b0, 32'h0);
    n_total++; if (instr_valid !== 1'b1 || instr_pc !== RESET_PC) $display("FAIL restart_pc: got %b/%h want 1/%h", instr_valid, instr_pc, RESET_PC); else n_pass++;
    n_total++; if (instr !== imem_mem[0]) $display("FAIL restart_instr: got %h want %h", instr, imem_mem[0]); else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    for (int i = 0; i < (1 << AW); i++) imem_mem[i] = $urandom;
    imem_mem[0] = 32'h20020005;
    test_reset();
    test_stall_fill();
    test_redirect_full();
    test_wrap();
    test_back_to_back_redirect();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
